// File: rtl/uart_pkg.sv
// Shared definitions for the serial link: transmitter state encoding, line
// levels, and a width helper used by the counters on both sides of the link.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each serial bit. Holding restart_i keeps it parked at zero, so the first
// cycle after restart_i drops is the first cycle of a fresh bit period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST_CNT);

  // Next count: wrap at the bit end so the following bit starts from zero.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples pre-edge values.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Serial transmitter: takes a word over valid/ready and sends it as
// start bit, DATA_W data bits LSB first, stop bit, each bit held for
// CLKS_PER_BIT clocks. The line output comes straight from a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int IDX_W = cnt_width(DATA_W);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              tx_q, tx_d;
  logic              bit_end;
  logic              accept;

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;
  assign accept   = tx_valid && tx_ready;

  // Parked at zero while idle, so START always gets a full bit period; the
  // counter's own wrap provides the restart on every later state entry.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk      (clk),
    .reset    (reset),
    .restart_i(state_q == IDLE),
    .tick_o   (bit_end)
  );

  // Next state, shift register and bit index; line level follows the next state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = UART_IDLE_LVL;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = tx_data;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d   = STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bit 0 of the shift register is always the data bit currently on the line.
    case (state_d)
      START:   tx_d = UART_START_LVL;
      DATA:    tx_d = shift_d[0];
      default: tx_d = UART_IDLE_LVL;
    endcase
  end

  // State, datapath and line registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= UART_IDLE_LVL;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (8 bits / 4 clocks per bit, and
// 5 bits / 2 clocks per bit), each shadowed by a frame-position model,
// plus directed frames with hand-computed bit patterns and latencies.
module tb_uart_tx;

  localparam int A_W = 8;
  localparam int A_C = 4;
  localparam int B_W = 5;
  localparam int B_C = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_a, reset_b;
  logic [A_W-1:0] tx_data_a;
  logic [B_W-1:0] tx_data_b;
  logic           tx_valid_a, tx_valid_b;
  logic           tx_ready_a, tx_ready_b;
  logic           tx_a, tx_b;
  logic           busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  uart_tx #(.DATA_W(A_W), .CLKS_PER_BIT(A_C)) dut_a (
    .clk     (clk),
    .reset   (reset_a),
    .tx_data (tx_data_a),
    .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a),
    .tx      (tx_a),
    .busy    (busy_a)
  );

  uart_tx #(.DATA_W(B_W), .CLKS_PER_BIT(B_C)) dut_b (
    .clk     (clk),
    .reset   (reset_b),
    .tx_data (tx_data_b),
    .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b),
    .tx      (tx_b),
    .busy    (busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line level at position t of a frame: segment 0 is the start bit,
  // segments 1..w carry data LSB first, segment w+1 is the stop bit.
  function automatic logic frame_bit(input int data, input int w, input int c, input int t);
    int seg;
    seg = t / c;
    if (seg == 0) return 1'b0;
    if (seg <= w) return data[seg-1];
    return 1'b1;
  endfunction

  // Model: position within the current frame (-1 when idle) and the word latched at accept.
  int pos_a = -1, mdata_a = 0;
  int pos_b = -1, mdata_b = 0;

  always @(posedge clk) begin
    if (reset_a) pos_a <= -1;
    else if (pos_a >= 0) pos_a <= (pos_a + 1 == (A_W + 2) * A_C) ? -1 : pos_a + 1;
    else if (tx_valid_a) begin
      pos_a   <= 0;
      mdata_a <= int'(tx_data_a);
    end
  end

  always @(posedge clk) begin
    if (reset_b) pos_b <= -1;
    else if (pos_b >= 0) pos_b <= (pos_b + 1 == (B_W + 2) * B_C) ? -1 : pos_b + 1;
    else if (tx_valid_b) begin
      pos_b   <= 0;
      mdata_b <= int'(tx_data_b);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("a_tx", tx_a, (pos_a < 0) ? 1'b1 : frame_bit(mdata_a, A_W, A_C, pos_a));
      check("a_ready", tx_ready_a, pos_a < 0);
      check("a_busy", busy_a, pos_a >= 0);
      check("b_tx", tx_b, (pos_b < 0) ? 1'b1 : frame_bit(mdata_b, B_W, B_C, pos_b));
      check("b_ready", tx_ready_b, pos_b < 0);
      check("b_busy", busy_b, pos_b >= 0);
    end
  end

  function automatic logic cur_ready(input bit sel);
    return sel ? tx_ready_b : tx_ready_a;
  endfunction

  function automatic logic cur_tx(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  // Offer a word and return #1 after the accept edge (frame position 0).
  task automatic send(input bit sel, input logic [8:0] data, input bit hold);
    bit ok;
    ok = 1'b0;
    if (sel) begin
      tx_data_b  = data[B_W-1:0];
      tx_valid_b = 1'b1;
    end else begin
      tx_data_a  = data[A_W-1:0];
      tx_valid_a = 1'b1;
    end
    for (int n = 0; n < 200 && !ok; n++) begin
      if (cur_ready(sel)) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!hold) begin
      if (sel) tx_valid_b = 1'b0;
      else tx_valid_a = 1'b0;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Sample the line at each bit centre and measure cycles until tx_ready returns.
  task automatic capture(input bit sel, input bit scramble,
                         output logic [15:0] bits, output int rdy_t);
    int c, w;
    c = sel ? B_C : A_C;
    w = sel ? B_W : A_W;
    bits  = '0;
    rdy_t = -1;
    for (int t = 0; t < 400; t++) begin
      if (t > 0 && cur_ready(sel)) begin
        rdy_t = t;
        break;
      end
      if ((t % c) == (c / 2) && (t / c) < (w + 2)) bits[t/c] = cur_tx(sel);
      if (scramble) tx_data_a = A_W'($urandom);
      @(posedge clk); #1;
    end
  endtask

  logic [15:0] bits;
  int          rdy_t;
  int          mism;
  logic        exp_bit;

  initial begin
    reset_a    = 1'b1;
    reset_b    = 1'b1;
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
    tx_data_a  = '0;
    tx_data_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    checking = 1'b1;
    check("reset_tx", tx_a, 1'b1);
    check("reset_ready", tx_ready_a, 1'b1);
    check("reset_busy", busy_a, 1'b0);

    // Reset held together with tx_valid: nothing may be accepted.
    tx_valid_a = 1'b1;
    tx_data_a  = 8'h99;
    @(posedge clk); #1;
    check("reset_wins_busy", busy_a, 1'b0);
    check("reset_wins_tx", tx_a, 1'b1);
    tx_valid_a = 1'b0;
    reset_a    = 1'b0;
    reset_b    = 1'b0;

    // Idle after reset release.
    repeat (50) @(posedge clk);
    #1;
    check("idle_tx", tx_a, 1'b1);
    check("idle_ready", tx_ready_a, 1'b1);
    check("idle_busy_b", busy_b, 1'b0);

    // 0xA5: start 0, data 1,0,1,0,0,1,0,1, stop 1; ready back after 40 cycles.
    send(1'b0, 9'h0A5, 1'b0);
    capture(1'b0, 1'b0, bits, rdy_t);
    check("a5_bits", bits, 16'b1_1010_0101_0);
    check("a5_ready_latency", rdy_t, 40);

    // Back-to-back 0x00 then 0xFF with tx_valid held: one idle cycle between frames.
    send(1'b0, 9'h000, 1'b1);
    tx_data_a = 8'hFF;
    mism = 0;
    for (int t = 0; t <= 80; t++) begin
      exp_bit = (t < 36) ? 1'b0 : (t < 41) ? 1'b1 : (t < 45) ? 1'b0 : 1'b1;
      if (tx_a !== exp_bit) mism++;
      if (t == 41) check("b2b_second_start", tx_a, 1'b0);
      if (t == 41) tx_valid_a = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b_stream_mismatches", mism, 0);
    check("b2b_ready_after", tx_ready_a, 1'b1);

    // 0x3C with tx_data changing every cycle during the frame.
    send(1'b0, 9'h03C, 1'b0);
    capture(1'b0, 1'b1, bits, rdy_t);
    check("3c_bits", bits, 16'b1_0011_1100_0);

    // 0x81 aborted by reset during the third data bit.
    send(1'b0, 9'h081, 1'b0);
    repeat (3 * A_C + 1) begin
      @(posedge clk); #1;
    end
    check("abort_before_bit2", tx_a, 1'b0);
    reset_a = 1'b1;
    @(posedge clk); #1;
    check("abort_tx", tx_a, 1'b1);
    check("abort_ready", tx_ready_a, 1'b1);
    check("abort_busy", busy_a, 1'b0);
    reset_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_resume", busy_a, 1'b0);

    // 0x55 after the abort goes out intact.
    send(1'b0, 9'h055, 1'b0);
    capture(1'b0, 1'b0, bits, rdy_t);
    check("55_bits", bits, 16'b1_0101_0101_0);
    check("55_ready_latency", rdy_t, 40);

    // Small instance: 5 bits, 2 clocks per bit, 0x1F -> 14-cycle frame 0,1,1,1,1,1,1.
    send(1'b1, 9'h01F, 1'b0);
    capture(1'b1, 1'b0, bits, rdy_t);
    check("b_1f_bits", bits, 16'b111_1110);
    check("b_1f_frame_len", rdy_t, 14);

    repeat (5) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the team's asynchronous serial link. It accepts a parallel data word through a valid/ready handshake and shifts it out on a single line, one bit at a time, framed as start bit, data bits LSB first, then stop bit. Each bit is held for a programmable number of clock cycles. It sits between any parallel producer (test logic, counters, register banks) and an external serial pin or the matching serial receiver.

## Interface
Parameters:
- DATA_W, default 8: data bits per frame; legal range 5..9.
- CLKS_PER_BIT, default 16: clock cycles each serial bit is held; must be ≥ 2.

Ports:
- clk, input, 1: the block's only clock; everything samples on its rising edge.
- reset, input, 1: synchronous, active-high reset; sampled on the rising edge of clk.
- tx_data, input, DATA_W: word to send; sampled only on the accept edge.
- tx_valid, input, 1: producer offers tx_data.
- tx_ready, output, 1: block can accept a word; high only in IDLE.
- tx, output, 1: serial line, registered; idle level 1.
- busy, output, 1: high from the cycle after accept until the end of the stop bit.

## Operation
- Reset values: state IDLE, tx=1, busy=0, tx_ready=1, baud and bit counters 0, shift register 0.
- Accept: tx_valid && tx_ready at a clk edge. The block latches tx_data into the shift register and moves to START. tx_data is ignored at all other times.
- FSM states and transitions:
  - IDLE → START on accept.
  - START: tx=0 for CLKS_PER_BIT cycles, then → DATA.
  - DATA: shifts out DATA_W bits, LSB first, each for CLKS_PER_BIT cycles. After bit DATA_W-1 → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then → IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and restarts on every state entry. The bit-end tick occurs when the counter equals CLKS_PER_BIT-1.
- Bit index runs 0..DATA_W-1 and is used only in DATA.
- Counter widths are $clog2(CLKS_PER_BIT) and $clog2(DATA_W) (minimum 1).
- tx_valid held high across frames: the next word is accepted on the first IDLE cycle, giving exactly one idle-high clock between the stop bit and the next start bit.
- tx_valid dropping mid-frame has no effect on the frame.
- Reset mid-frame aborts the frame. At the next edge tx=1, state is IDLE, and the aborted data is discarded with no resumption.
- Reset asserted together with tx_valid: reset wins and no word is accepted.

## Timing
- Accept edge E. From E+1, tx=0 (start bit) for CLKS_PER_BIT cycles.
- Data bit k occupies cycles E+1+(k+1)·CLKS_PER_BIT … E+(k+2)·CLKS_PER_BIT.
- Stop bit ends at E+(DATA_W+2)·CLKS_PER_BIT. tx_ready=1 and busy=0 in the following cycle.
- Frame length is (DATA_W+2)·CLKS_PER_BIT cycles. With defaults this is 160 cycles.
- tx_ready is decoded directly from the state register, so it carries no extra latency. tx is driven from a flop and is glitch-free.

## Structure
- Shared package uart_pkg holds:
  - typedef enum tx_state_t {IDLE, START, DATA, STOP}.
  - constants UART_IDLE_LVL=1'b1 and UART_START_LVL=1'b0, reused by the future receiver.
- One sub-module, uart_baud_cnt: a parameterised cycle counter with a restart input and a bit-end tick output. It is instantiated here and reused by the receiver.
- The FSM, shift register and bit index live in uart_tx itself.

## Test plan
- Reset release, then idle for 50 cycles → tx=1, tx_ready=1, busy=0 throughout.
- DATA_W=8, CLKS_PER_BIT=4, send 0xA5 → tx samples at bit centres read 0, 1,0,1,0,0,1,0,1, 1. tx_ready returns high 40 cycles after the accept edge.
- tx_valid held high with words 0x00 then 0xFF → second start bit begins exactly 1 cycle after the first stop bit ends. Data bits read all 0, then all 1.
- Change tx_data every cycle during a frame of 0x3C → transmitted bits remain 0x3C.
- Assert reset at the 3rd data bit of 0x81 → tx=1 and tx_ready=1 at the next edge. A following send of 0x55 is transmitted intact.
- CLKS_PER_BIT=2, DATA_W=5, send 0x1F → frame is exactly 14 cycles; bit stream 0,1,1,1,1,1,1.
